// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: lane width, lane type and the window-counter width helper.
package cnn_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] lane_t;

    // A one-entry window still needs a one-bit counter so the logic stays uniform.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max_pool_if.sv
// Stream interface for max_pool: input vector handshake, clear, and result handshake.
interface max_pool_if #(
    parameter int SIZE = 4
);
    import cnn_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W*SIZE-1:0] a;
    logic                   clear;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W*SIZE-1:0] pool_out;

    modport master (
        output in_valid, a, clear, out_ready,
        input  in_ready, out_valid, pool_out
    );

    modport slave (
        input  in_valid, a, clear, out_ready,
        output in_ready, out_valid, pool_out
    );

endinterface

// File: rtl/pool_lane_max.sv
// Single-lane unsigned maximum used by the max_pool lane array.
module pool_lane_max
    import cnn_pkg::*;
(
    input  lane_t x_i,
    input  lane_t y_i,
    output lane_t max_o
);

    assign max_o = (y_i > x_i) ? y_i : x_i;

endmodule

// File: rtl/max_pool.sv
// 1-D max pooling over POOL accepted SIZE-lane vectors with registered, back-pressured output.
// Optional build macro MAX_POOL_RELU_EN clamps each result lane to ZERO_POINT at pool_out load.
module max_pool
    import cnn_pkg::*;
#(
    parameter int    SIZE       = 4,
    parameter int    POOL       = 2,
    parameter lane_t ZERO_POINT = 8'd0
) (
    input logic       clock,
    input logic       reset,
    max_pool_if.slave bus
);

    localparam int            CW   = cnt_width(POOL);
    localparam int            VW   = DATA_W * SIZE;
    localparam logic [CW-1:0] LAST = CW'(POOL - 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic [VW-1:0] acc_q, acc_d;
    logic [VW-1:0] pool_q, pool_d;
    logic [VW-1:0] sel_vec, res_vec;
    logic          out_valid_q, out_valid_d;
    logic          accept, consume, first;

    function automatic lane_t relu(input lane_t x);
`ifdef MAX_POOL_RELU_EN
        return (x < ZERO_POINT) ? ZERO_POINT : x;
`else
        return x;
`endif
    endfunction

    if (POOL < 1 || POOL > 16) begin : g_pool_range
        $error("max_pool: POOL must be in 1..16");
    end

`ifndef MAX_POOL_RELU_EN
    // ZERO_POINT only matters when the clamp is compiled in.
    if (ZERO_POINT != 8'd0) begin : g_zero_point_ignored
    end
`endif

    assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.pool_out  = pool_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = out_valid_q && bus.out_ready;
    // A clear in the same cycle makes the incoming vector the first of a fresh window.
    assign cnt_eff = bus.clear ? '0 : cnt_q;
    assign first   = (cnt_eff == '0);

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        lane_t max_w;

        pool_lane_max u_max (
            .x_i  (acc_q[DATA_W*i +: DATA_W]),
            .y_i  (bus.a[DATA_W*i +: DATA_W]),
            .max_o(max_w)
        );

        assign sel_vec[DATA_W*i +: DATA_W] = first ? bus.a[DATA_W*i +: DATA_W] : max_w;
        assign res_vec[DATA_W*i +: DATA_W] = relu(sel_vec[DATA_W*i +: DATA_W]);
    end

    always_comb begin
        cnt_d       = cnt_eff;
        acc_d       = acc_q;
        pool_d      = pool_q;
        out_valid_d = out_valid_q;
        if (consume) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (cnt_eff == LAST) begin
                pool_d      = res_vec;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end else begin
                acc_d = sel_vec;
                cnt_d = cnt_eff + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            pool_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            pool_q      <= pool_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
